// File: rtl/wb_write_queue_pkg.sv
// wbq_pkg: shared defaults, entry type and constants for the writeback queue.
// Optional feature macro used by this slice: WBQ_FORCE_DRAIN_EN.
package wbq_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;

    // Register 0 is hard-wired; writes to it are dropped and reads never bypass.
    localparam int REG_ZERO = 0;

endpackage : wbq_pkg

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: writeback push, decode read/bypass and register-file
// write signals of the writeback queue, bundled with master/slave views.
// With WBQ_FORCE_DRAIN_EN defined the bundle also carries DecStall.
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              WbValid;
    logic [ADDR_W-1:0] WbRegister;
    logic [DATA_W-1:0] WbData;
    logic              WbReady;
    logic              RdReq;
    logic [ADDR_W-1:0] RdRegister1;
    logic [ADDR_W-1:0] RdRegister2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              Bypass1Hit;
    logic [DATA_W-1:0] Bypass1Data;
    logic              Bypass2Hit;
    logic [DATA_W-1:0] Bypass2Data;
    logic [CNT_W-1:0]  Count;
`ifdef WBQ_FORCE_DRAIN_EN
    logic              DecStall;

    modport master (
        output WbValid, WbRegister, WbData, RdReq, RdRegister1, RdRegister2,
        input  WbReady, RegWrite, WriteRegister, WriteData,
        input  Bypass1Hit, Bypass1Data, Bypass2Hit, Bypass2Data, Count, DecStall
    );
    modport slave (
        input  WbValid, WbRegister, WbData, RdReq, RdRegister1, RdRegister2,
        output WbReady, RegWrite, WriteRegister, WriteData,
        output Bypass1Hit, Bypass1Data, Bypass2Hit, Bypass2Data, Count, DecStall
    );
`else
    modport master (
        output WbValid, WbRegister, WbData, RdReq, RdRegister1, RdRegister2,
        input  WbReady, RegWrite, WriteRegister, WriteData,
        input  Bypass1Hit, Bypass1Data, Bypass2Hit, Bypass2Data, Count
    );
    modport slave (
        input  WbValid, WbRegister, WbData, RdReq, RdRegister1, RdRegister2,
        output WbReady, RegWrite, WriteRegister, WriteData,
        output Bypass1Hit, Bypass1Data, Bypass2Hit, Bypass2Data, Count
    );
`endif

endinterface : wb_write_queue_if

// File: rtl/wb_write_queue_bypass_match.sv
// wbq_bypass_match: combinational youngest-match lookup for one decode read
// port. Queue entries arrive age-ordered (index 0 = oldest); the same-cycle
// incoming write is younger than every queued entry.
module wbq_bypass_match
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] RdRegister,
    input  logic              PushValid,
    input  logic [ADDR_W-1:0] PushAddr,
    input  logic [DATA_W-1:0] PushData,
    input  logic [ADDR_W-1:0] QueueAddr [DEPTH],
    input  logic [DATA_W-1:0] QueueData [DEPTH],
    input  logic [DEPTH-1:0]  QueueValid,
    output logic              Hit,
    output logic [DATA_W-1:0] Data
);

    // Scan oldest to youngest so the last (youngest) match wins.
    always_comb begin
        Hit  = 1'b0;
        Data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (QueueValid[i] && (QueueAddr[i] == RdRegister)) begin
                Hit  = 1'b1;
                Data = QueueData[i];
            end
        end
        if (PushValid && (PushAddr == RdRegister)) begin
            Hit  = 1'b1;
            Data = PushData;
        end
        if (RdRegister == ADDR_W'(REG_ZERO)) begin
            Hit  = 1'b0;
            Data = '0;
        end
    end

endmodule : wbq_bypass_match

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO of pending writeback results in front of a register
// file that cannot read and write on the same edge. Drains the head on every
// non-read edge and supplies registered bypass data for reads of pending writes.
// Optional feature macro: WBQ_FORCE_DRAIN_EN (full queue + read forces a drain
// and raises DecStall so decode retries).
module wb_write_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wbq_pkg::DATA_W,
    parameter int ADDR_W = wbq_pkg::ADDR_W
) (
    input  logic           Clk,
    input  logic           Reset,
    wb_write_queue_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] memAddr [DEPTH];
    logic [DATA_W-1:0] memData [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  countReg;

    logic              full;
    logic              accept;
    logic              enqueue;
    logic              drain;
    logic              forceDrain;
    logic              readEdge;

    logic [ADDR_W-1:0] ordAddr [DEPTH];
    logic [DATA_W-1:0] ordData [DEPTH];
    logic [DEPTH-1:0]  ordValid;

    logic              hit1Next;
    logic              hit2Next;
    logic [DATA_W-1:0] data1Next;
    logic [DATA_W-1:0] data2Next;
    logic              hit1Reg;
    logic              hit2Reg;
    logic [DATA_W-1:0] data1Reg;
    logic [DATA_W-1:0] data2Reg;

    assign full    = (countReg == CNT_W'(DEPTH));
    assign accept  = bus.WbValid && !full;
    // Writes to register 0 are acknowledged but never stored.
    assign enqueue = accept && (bus.WbRegister != ADDR_W'(REG_ZERO));

`ifdef WBQ_FORCE_DRAIN_EN
    assign forceDrain   = full && bus.RdReq;
    assign bus.DecStall = forceDrain;
`else
    assign forceDrain   = 1'b0;
`endif

    assign drain    = (countReg != '0) && (!bus.RdReq || forceDrain);
    // A forced drain steals the register-file port, so that edge is not a read.
    assign readEdge = bus.RdReq && !forceDrain;

    assign bus.WbReady       = !full;
    assign bus.RegWrite      = drain;
    assign bus.WriteRegister = memAddr[headPtr];
    assign bus.WriteData     = memData[headPtr];
    assign bus.Count         = countReg;
    assign bus.Bypass1Hit    = hit1Reg;
    assign bus.Bypass1Data   = data1Reg;
    assign bus.Bypass2Hit    = hit2Reg;
    assign bus.Bypass2Data   = data2Reg;

    // Present the queue in age order (0 = head) for the bypass search.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_order
        assign ordAddr[gi]  = memAddr[PTR_W'(headPtr + PTR_W'(gi))];
        assign ordData[gi]  = memData[PTR_W'(headPtr + PTR_W'(gi))];
        assign ordValid[gi] = (CNT_W'(gi) < countReg);
    end

    wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match1 (
        .RdRegister (bus.RdRegister1),
        .PushValid  (enqueue),
        .PushAddr   (bus.WbRegister),
        .PushData   (bus.WbData),
        .QueueAddr  (ordAddr),
        .QueueData  (ordData),
        .QueueValid (ordValid),
        .Hit        (hit1Next),
        .Data       (data1Next)
    );

    wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match2 (
        .RdRegister (bus.RdRegister2),
        .PushValid  (enqueue),
        .PushAddr   (bus.WbRegister),
        .PushData   (bus.WbData),
        .QueueAddr  (ordAddr),
        .QueueData  (ordData),
        .QueueValid (ordValid),
        .Hit        (hit2Next),
        .Data       (data2Next)
    );

    // Queue storage: contents need no reset, validity is tracked by the count.
    always_ff @(posedge Clk) begin
        if (enqueue) begin
            memAddr[tailPtr] <= bus.WbRegister;
            memData[tailPtr] <= bus.WbData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
        end else begin
            if (enqueue) tailPtr <= tailPtr + 1'b1;
            if (drain)   headPtr <= headPtr + 1'b1;
            if (enqueue && !drain)      countReg <= countReg + 1'b1;
            else if (!enqueue && drain) countReg <= countReg - 1'b1;
        end
    end

    // Bypass results update only on read edges, tracking the register file's ReadData.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit1Reg  <= 1'b0;
            hit2Reg  <= 1'b0;
            data1Reg <= '0;
            data2Reg <= '0;
        end else if (readEdge) begin
            hit1Reg  <= hit1Next;
            hit2Reg  <= hit2Next;
            data1Reg <= data1Next;
            data2Reg <= data2Next;
        end
    end

endmodule : wb_write_queue
